// File: rtl/stream_channel_mux.sv
// rtl/stream_channel_mux.sv - NUM_CH-to-1 valid/ready stream mux with fixed-select or round-robin grant
// The output is a one-entry register that can drain and reload on the same edge.
module stream_channel_mux #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic [NUM_CH*WIDTH-1:0] In_Data,
  input  logic [NUM_CH-1:0]       In_Valid,
  output logic [NUM_CH-1:0]       In_Ready,
  input  logic [SEL_W-1:0]        Select,
  input  logic                    Mode,
  output logic [WIDTH-1:0]        Out_Data,
  output logic [SEL_W-1:0]        Out_Chan,
  output logic                    Out_Valid,
  input  logic                    Out_Ready
);

  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load_en;
  logic             fix_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  assign load_en = ~out_valid_q | Out_Ready;

  // An out-of-range Select matches no channel, so the grant is simply absent.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (Select == SEL_W'(i)) fix_valid = In_Valid[i];
    end
  end

  // Scan distances from NUM_CH down to 1 so the nearest valid channel after last_q wins.
  always_comb begin
    rr_grant = '0;
    for (int d = NUM_CH; d >= 1; d--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (In_Valid[i] && (i == (int'(last_q) + d) % NUM_CH)) rr_grant = SEL_W'(i);
      end
    end
  end

  assign rr_valid    = |In_Valid;
  assign grant_valid = Mode ? rr_valid : fix_valid;
  assign grant       = Mode ? rr_grant : Select;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) grant_data = In_Data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    In_Ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      In_Ready[i] = load_en & grant_valid & (grant == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load_en) begin
      if (grant_valid) begin
        out_data_d  = grant_data;
        out_chan_d  = grant;
        out_valid_d = 1'b1;
        last_d      = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Chan  = out_chan_q;
  assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_stream_channel_mux.sv
// tb/tb_stream_channel_mux.sv - checks three mux configurations against a behavioural model
module tb_stream_channel_mux;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic Reset_n;

  // a: WIDTH=4 NUM_CH=2 SEL_W=1
  logic [7:0]  a_data;  logic [1:0] a_valid, a_ready; logic [0:0] a_sel, a_chan;
  logic        a_mode, a_ovalid, a_ordy;              logic [3:0] a_odata;
  // b: WIDTH=8 NUM_CH=4 SEL_W=2
  logic [31:0] b_data;  logic [3:0] b_valid, b_ready; logic [1:0] b_sel, b_chan;
  logic        b_mode, b_ovalid, b_ordy;              logic [7:0] b_odata;
  // c: WIDTH=4 NUM_CH=3 SEL_W=2
  logic [11:0] c_data;  logic [2:0] c_valid, c_ready; logic [1:0] c_sel, c_chan;
  logic        c_mode, c_ovalid, c_ordy;              logic [3:0] c_odata;

  stream_channel_mux #(.WIDTH(4), .NUM_CH(2), .SEL_W(1)) u_a (
    .Clock(Clock), .Reset_n(Reset_n), .In_Data(a_data), .In_Valid(a_valid), .In_Ready(a_ready),
    .Select(a_sel), .Mode(a_mode), .Out_Data(a_odata), .Out_Chan(a_chan), .Out_Valid(a_ovalid),
    .Out_Ready(a_ordy));
  stream_channel_mux #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) u_b (
    .Clock(Clock), .Reset_n(Reset_n), .In_Data(b_data), .In_Valid(b_valid), .In_Ready(b_ready),
    .Select(b_sel), .Mode(b_mode), .Out_Data(b_odata), .Out_Chan(b_chan), .Out_Valid(b_ovalid),
    .Out_Ready(b_ordy));
  stream_channel_mux #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) u_c (
    .Clock(Clock), .Reset_n(Reset_n), .In_Data(c_data), .In_Valid(c_valid), .In_Ready(c_ready),
    .Select(c_sel), .Mode(c_mode), .Out_Data(c_odata), .Out_Chan(c_chan), .Out_Valid(c_ovalid),
    .Out_Ready(c_ordy));

  int n_assert = 0;
  int n_fail   = 0;

  int m_n[3] = '{2, 4, 3};
  int m_w[3] = '{4, 8, 4};
  bit m_ov[3];
  int m_od[3];
  int m_oc[3];
  int m_last[3];
  bit p_load[3];
  bit p_gv[3];
  int p_g[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ov[k] = 1'b0; m_od[k] = 0; m_oc[k] = 0; m_last[k] = m_n[k] - 1;
    end
  endtask

  // Grant rule: fixed select if in range and valid, else nearest valid channel after the last winner.
  task automatic model_eval(input int k, input int v, input int sel, input bit mode,
                            input bit ordy, output int exp_ready);
    int  n;
    bit  gv;
    int  g;
    int  c;
    n  = m_n[k];
    gv = 1'b0;
    g  = 0;
    if (!mode) begin
      if (sel < n && v[sel]) begin gv = 1'b1; g = sel; end
    end else begin
      for (int d = 1; d <= n && !gv; d++) begin
        c = (m_last[k] + d) % n;
        if (v[c]) begin gv = 1'b1; g = c; end
      end
    end
    p_load[k] = !m_ov[k] || ordy;
    p_gv[k]   = gv;
    p_g[k]    = g;
    exp_ready = (p_load[k] && gv) ? (1 << g) : 0;
  endtask

  task automatic model_commit(input int k, input logic [31:0] data);
    if (p_load[k]) begin
      if (p_gv[k]) begin
        m_ov[k]   = 1'b1;
        m_od[k]   = int'(data >> (p_g[k] * m_w[k])) & ((1 << m_w[k]) - 1);
        m_oc[k]   = p_g[k];
        m_last[k] = p_g[k];
      end else begin
        m_ov[k] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    int ea, eb, ec;
    #1;
    model_eval(0, int'(a_valid), int'(a_sel), a_mode, a_ordy, ea);
    model_eval(1, int'(b_valid), int'(b_sel), b_mode, b_ordy, eb);
    model_eval(2, int'(c_valid), int'(c_sel), c_mode, c_ordy, ec);
    chk("a_in_ready", 32'(a_ready), ea);
    chk("b_in_ready", 32'(b_ready), eb);
    chk("c_in_ready", 32'(c_ready), ec);
    @(posedge Clock);
    model_commit(0, 32'(a_data));
    model_commit(1, b_data);
    model_commit(2, 32'(c_data));
    #1;
    chk("a_out_valid", 32'(a_ovalid), 32'(m_ov[0]));
    chk("a_out_data",  32'(a_odata),  m_od[0]);
    chk("a_out_chan",  32'(a_chan),   m_oc[0]);
    chk("b_out_valid", 32'(b_ovalid), 32'(m_ov[1]));
    chk("b_out_data",  32'(b_odata),  m_od[1]);
    chk("b_out_chan",  32'(b_chan),   m_oc[1]);
    chk("c_out_valid", 32'(c_ovalid), 32'(m_ov[2]));
    chk("c_out_data",  32'(c_odata),  m_od[2]);
    chk("c_out_chan",  32'(c_chan),   m_oc[2]);
    @(negedge Clock);
  endtask

  // Pulses reset between edges and checks the asynchronous clear; returns before the next rising edge.
  task automatic do_reset();
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_a_valid", 32'(a_ovalid), 0); chk("rst_a_data", 32'(a_odata), 0); chk("rst_a_chan", 32'(a_chan), 0);
    chk("rst_b_valid", 32'(b_ovalid), 0); chk("rst_b_data", 32'(b_odata), 0); chk("rst_b_chan", 32'(b_chan), 0);
    chk("rst_c_valid", 32'(c_ovalid), 0); chk("rst_c_data", 32'(c_odata), 0); chk("rst_c_chan", 32'(c_chan), 0);
    model_reset();
    #1 Reset_n = 1'b1;
  endtask

  int exp4[4] = '{3, 1, 3, 1};

  initial begin
    Reset_n = 1'b1;
    a_data = '0; a_valid = '0; a_sel = '0; a_mode = 1'b0; a_ordy = 1'b1;
    b_data = '0; b_valid = '0; b_sel = '0; b_mode = 1'b0; b_ordy = 1'b1;
    c_data = '0; c_valid = '0; c_sel = '0; c_mode = 1'b0; c_ordy = 1'b1;
    model_reset();
    do_reset();

    // fixed select of channel 1
    a_mode = 1'b0; a_sel = 1'b1; a_data = {4'hA, 4'h5}; a_valid = 2'b11; a_ordy = 1'b1;
    #1 chk("t1_in_ready", 32'(a_ready), 32'h2);
    cycle();
    chk("t1_data", 32'(a_odata), 32'hA);
    chk("t1_chan", 32'(a_chan), 1);

    // stall for three cycles, then drain and load on the same edge
    a_sel = 1'b0;
    cycle();
    a_ordy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("t2_stall_ready", 32'(a_ready), 0);
      chk("t2_stall_data", 32'(a_odata), 32'h5);
    end
    a_ordy = 1'b1; a_data = {4'hA, 4'h3};
    cycle();
    chk("t2_nobubble_valid", 32'(a_ovalid), 1);
    chk("t2_nobubble_data", 32'(a_odata), 32'h3);
    a_valid = '0;

    // round-robin fairness with all four channels valid
    b_mode = 1'b1; b_valid = 4'hF; b_ordy = 1'b1; b_data = 32'hD4C3B2A1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("t3_rr_chan", 32'(b_chan), j % 4);
    end

    // only channels 1 and 3 valid; last winner was 1
    b_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("t4_rr_chan", 32'(b_chan), exp4[j]);
    end
    b_valid = '0;

    // out-of-range select on the three-channel instance
    c_mode = 1'b0; c_ordy = 1'b1; c_valid = 3'b111; c_data = {4'h9, 4'h6, 4'h2}; c_sel = 2'd2;
    cycle();
    chk("t5_load_data", 32'(c_odata), 32'h9);
    c_sel = 2'd3;
    cycle();
    chk("t5_oor_ready", 32'(c_ready), 0);
    chk("t5_oor_valid", 32'(c_ovalid), 0);
    chk("t5_oor_hold", 32'(c_odata), 32'h9);
    c_valid = '0;

    // reset while a word is held; priority restarts at channel 0
    b_mode = 1'b1; b_valid = 4'hF; b_ordy = 1'b0; b_data = 32'h44332211;
    cycle();
    cycle();
    chk("t6_held_valid", 32'(b_ovalid), 1);
    do_reset();
    b_ordy = 1'b1;
    cycle();
    chk("t6_first_chan", 32'(b_chan), 0);
    chk("t6_first_data", 32'(b_odata), 32'h11);

    // randomized traffic on all instances
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      a_data = 8'($urandom());  a_valid = 2'($urandom()); a_sel = 1'($urandom());
      a_mode = 1'($urandom());  a_ordy = ($urandom_range(0, 3) != 0);
      b_data = $urandom();      b_valid = 4'($urandom()); b_sel = 2'($urandom());
      b_mode = 1'($urandom());  b_ordy = ($urandom_range(0, 3) != 0);
      c_data = 12'($urandom()); c_valid = 3'($urandom()); c_sel = 2'($urandom());
      c_mode = 1'($urandom());  c_ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_channel_mux.md
Name: stream_channel_mux

Overview:
- Parametrised successor to the 4-bit 2x1 mux: NUM_CH channels, WIDTH bits each, one output stream.
- Each input channel and the output use a valid/ready handshake.
- Output is registered (one-entry buffer).
- Two modes: Mode=0 fixed select (Select port picks the channel); Mode=1 round-robin arbitration across valid channels.
- Sits between the adder/subtractor operand sources and the arithmetic datapath, replacing hard-wired 2x1 operand muxes.

Parameters:
- WIDTH, 4, data bits per channel.
- NUM_CH, 2, number of input channels; legal range 2..2**SEL_W.
- SEL_W, 1, width of Select and Out_Chan.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- In_Data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- In_Valid  input  NUM_CH  per-channel valid.
- In_Ready  output  NUM_CH  per-channel ready; combinational; at most one bit high.
- Select  input  SEL_W  channel index, used in Mode 0.
- Mode  input  1  0 = fixed select, 1 = round-robin.
- Out_Data  output  WIDTH  registered output data.
- Out_Chan  output  SEL_W  index of the channel that produced Out_Data.
- Out_Valid  output  1  output holds a word.
- Out_Ready  input  1  downstream accepts the word.

Behaviour:
- Clock and reset: one clock, Clock; reset is asynchronous and active-low, Reset_n.
- Reset values (asserted asynchronously, independent of Clock):
  - Out_Valid=0, Out_Data=0, Out_Chan=0.
  - Internal Last pointer = NUM_CH-1, so channel 0 has first round-robin priority.
- Load_En = ~Out_Valid | Out_Ready. The output register accepts a new word when empty or draining in the same cycle.
- Grant, Mode 0:
  - Grant_Valid = (Select < NUM_CH) & In_Valid[Select]; Grant = Select.
  - Select >= NUM_CH gives no grant and never produces X.
- Grant, Mode 1:
  - Grant = first i with In_Valid[i]=1, scanning Last+1, Last+2, ... modulo NUM_CH.
  - Grant_Valid = |In_Valid.
- In_Ready[i] = Load_En & Grant_Valid & (Grant==i). All other bits are 0.
- In_Ready must not depend on In_Data. It may depend on In_Valid, Select, Mode, Out_Valid and Out_Ready.
- Rising edge with Load_En & Grant_Valid:
  - Out_Data <= channel Grant data; Out_Chan <= Grant; Out_Valid <= 1.
  - Last <= Grant. Last is updated in both modes.
- Rising edge with Load_En & ~Grant_Valid: Out_Valid <= 0. Out_Data and Out_Chan hold their old values.
- Rising edge with ~Load_En (Out_Valid=1, Out_Ready=0): Out_Data, Out_Chan and Out_Valid hold exactly. The source is not acknowledged.
- Latency: 1 cycle from an input handshake to Out_Valid.
- Throughput: 1 word per cycle with Out_Ready held high.
- Simultaneous drain and load: the old word leaves, the new word loads on the same edge, and Out_Valid stays 1 with no bubble.
- Select or Mode changes: take effect on the next grant evaluation. A word already registered is unaffected.
- Round-robin fairness: with all channels valid and Out_Ready=1, grants rotate 0,1,...,NUM_CH-1,0,... with no repeats.
- Reset mid-operation: a held output word is discarded and the next grant restarts priority at channel 0.

Test Plan:
- Mode 0, WIDTH=4, NUM_CH=2, Select=1, In_Data={4'hA,4'h5}, both valid, Out_Ready=1 -> In_Ready=2'b10; next cycle Out_Data=4'hA, Out_Chan=1, Out_Valid=1.
- Mode 0, Select=0, Out_Ready=0 for 3 cycles after the first load -> In_Ready=0 during the stall; Out_Data stays 4'h5; on Out_Ready=1 the next word loads the same cycle with no bubble.
- Mode 1, NUM_CH=4, all valid continuously, Out_Ready=1 -> Out_Chan sequence 0,1,2,3,0,1 on consecutive cycles.
- Mode 1, only channels 1 and 3 valid -> Out_Chan sequence alternates 1,3,1,3; In_Ready[0] and In_Ready[2] stay 0.
- Mode 0, NUM_CH=3, SEL_W=2, Select=3 -> In_Ready=0 and Out_Valid falls to 0 after draining; no X on any output.
- Reset_n pulsed low between clock edges while Out_Valid=1 -> Out_Valid=0 and Out_Data=0 immediately; after release, in Mode 1 the first grant goes to channel 0.
